// File: rtl/isa_io_bridge.sv
// isa_io_bridge: Avalon-MM slave to ISA I/O-cycle master. It has programmable setup/strobe/hold
// timing, 16-to-8-bit cycle splitting, ISA reset sequencing and edge-latched IRQ inputs.
// Define ISA_BRIDGE_IOCHRDY_EN to enable IOCHRDY wait states, the ready timeout and timeout_err.
module isa_io_bridge #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 6,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RDY_TIMEOUT = 255,
  parameter int unsigned RESET_CYC   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [1:0]         avs_byteenable,
  input  logic [15:0]        avs_writedata,
  output logic [15:0]        avs_readdata,
  output logic               avs_waitrequest,
  output logic [ADDR_W-1:0]  isa_address,
  output logic               isa_aen,
  output logic [15:0]        isa_data_o,
  input  logic [15:0]        isa_data_i,
  output logic               isa_data_oe,
  output logic               isa_ior_n,
  output logic               isa_iow_n,
  input  logic               isa_iochrdy,
  input  logic               isa_iocs16_n,
  output logic               isa_reset,
  input  logic [NUM_IRQ-1:0] isa_irq,
  output logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_clear,
  output logic               timeout_err,
  input  logic               timeout_clear
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT_RDY, S_HOLD, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CNT_W-1:0]   rst_cnt;
  logic [15:0]        rdata, rdata_d, lane_src_c;
  logic [ADDR_W-1:0]  addr_d;
  logic [15:0]        dout_d;
  logic               wr, wr_d, hi, hi_d, pair, pair_d, wide, wide_d, more, more_d;
  logic               capture_c, fill_c, tmo_set_c, bus_c, strb_c;
  logic [NUM_IRQ-1:0] irq_s1, irq_s2, irq_s3;
  logic               rdy_sync;

`ifdef ISA_BRIDGE_IOCHRDY_EN
  logic rdy_s1;

  // IOCHRDY synchroniser; idles ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_s1   <= 1'b1;
      rdy_sync <= 1'b1;
    end else begin
      rdy_s1   <= isa_iochrdy;
      rdy_sync <= rdy_s1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              timeout_err <= 1'b0;
    else if (tmo_set_c)     timeout_err <= 1'b1;
    else if (timeout_clear) timeout_err <= 1'b0;
  end
`else
  logic unused_ok;
  assign rdy_sync    = 1'b1;
  assign timeout_err = 1'b0;
  assign unused_ok   = &{1'b0, isa_iochrdy, timeout_clear, rdy_sync};
`endif

  // Next-state, transaction bookkeeping and read-lane capture
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    wr_d      = wr;
    hi_d      = hi;
    pair_d    = pair;
    wide_d    = wide;
    more_d    = more;
    rdata_d   = rdata;
    addr_d    = isa_address;
    dout_d    = isa_data_o;
    capture_c = 1'b0;
    fill_c    = 1'b0;
    tmo_set_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (!isa_reset && (avs_read || avs_write)) begin
          wr_d    = avs_write;
          pair_d  = (avs_byteenable == 2'b11);
          hi_d    = (avs_byteenable == 2'b10);
          wide_d  = 1'b0;
          more_d  = 1'b0;
          rdata_d = '0;
          cnt_d   = '0;
          addr_d  = avs_address + ADDR_W'(hi_d);
          dout_d  = hi_d ? {8'h00, avs_writedata[15:8]} : avs_writedata;
          state_d = (avs_byteenable == 2'b00) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_STROBE;
          if (pair && !hi) begin
            wide_d = !isa_iocs16_n;
            more_d = isa_iocs16_n;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == CNT_W'(STROBE_CYC - 1)) begin
          cnt_d = '0;
          if (!rdy_sync) begin
            state_d = S_WAIT_RDY;
          end else begin
            capture_c = 1'b1;
            state_d   = S_HOLD;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`ifdef ISA_BRIDGE_IOCHRDY_EN
      S_WAIT_RDY: begin
        if (rdy_sync) begin
          capture_c = 1'b1;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else if (cnt == CNT_W'(RDY_TIMEOUT - 1)) begin
          fill_c    = 1'b1;
          tmo_set_c = 1'b1;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif
      S_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          if (more) begin
            more_d  = 1'b0;
            hi_d    = 1'b1;
            addr_d  = isa_address + ADDR_W'(1);
            dout_d  = {8'h00, isa_data_o[15:8]};
            state_d = S_SETUP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    lane_src_c = fill_c ? 16'hFFFF : isa_data_i;
    if ((capture_c || fill_c) && !wr) begin
      if (wide)    rdata_d       = lane_src_c;
      else if (hi) rdata_d[15:8] = lane_src_c[7:0];
      else         rdata_d[7:0]  = lane_src_c[7:0];
    end
    bus_c  = (state_d == S_SETUP) || (state_d == S_STROBE) ||
             (state_d == S_WAIT_RDY) || (state_d == S_HOLD);
    strb_c = (state_d == S_STROBE) || (state_d == S_WAIT_RDY);
  end

  // State, bookkeeping and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      wr              <= 1'b0;
      hi              <= 1'b0;
      pair            <= 1'b0;
      wide            <= 1'b0;
      more            <= 1'b0;
      rdata           <= '0;
      avs_readdata    <= '0;
      avs_waitrequest <= 1'b1;
      isa_address     <= '0;
      isa_aen         <= 1'b1;
      isa_data_o      <= '0;
      isa_data_oe     <= 1'b0;
      isa_ior_n       <= 1'b1;
      isa_iow_n       <= 1'b1;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      wr              <= wr_d;
      hi              <= hi_d;
      pair            <= pair_d;
      wide            <= wide_d;
      more            <= more_d;
      rdata           <= rdata_d;
      if (state_d == S_DONE) avs_readdata <= rdata_d;
      avs_waitrequest <= (state_d != S_DONE);
      isa_address     <= addr_d;
      isa_aen         <= !bus_c;
      isa_data_o      <= dout_d;
      isa_data_oe     <= bus_c && wr_d;
      isa_ior_n       <= !(strb_c && !wr_d);
      isa_iow_n       <= !(strb_c && wr_d);
    end
  end

  // ISA RESET DRV held for RESET_CYC cycles after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_cnt   <= CNT_W'(RESET_CYC);
      isa_reset <= 1'b1;
    end else begin
      if (rst_cnt != '0) rst_cnt <= rst_cnt - CNT_W'(1);
      isa_reset <= (rst_cnt > CNT_W'(1));
    end
  end

  // IRQ synchronisers and rising-edge latches; a new edge beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1      <= '0;
      irq_s2      <= '0;
      irq_s3      <= '0;
      irq_pending <= '0;
    end else begin
      irq_s1      <= isa_irq;
      irq_s2      <= irq_s1;
      irq_s3      <= irq_s2;
      irq_pending <= (irq_pending & ~irq_clear) | (irq_s2 & ~irq_s3);
    end
  end

endmodule
